rob_commit_controller: RTL

//  Sequences retirement at the reorder-buffer head: one entry per cycle max. Writes results to the

---
 rtl/rob_commit_controller_pkg.sv | 18 +
 rtl/rob_commit_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rob_commit_controller_pkg.sv
// Shared encodings for the ROB commit controller.
// Instruction kinds at the ROB head and commit FSM states.
package rob_commit_controller_pkg;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_JUMP  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_COMMIT     = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } commit_state_e;

endpackage

// File: rtl/rob_commit_controller.sv
// Retires one ROB head entry per cycle.
// Drives regfile writes, store release, predictor update, flush.
module rob_commit_controller
  import rob_commit_controller_pkg::*;
#(
  parameter int ROB_W        = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              head_valid_in,
  input  logic              head_ready_in,
  input  logic [1:0]        head_kind_in,
  input  logic [ROB_W-1:0]  head_rob_id_in,
  input  logic [REG_W-1:0]  head_rd_in,
  input  logic [DATA_W-1:0] head_value_in,
  input  logic              head_pred_jumped_in,
  input  logic              head_real_jumped_in,
  input  logic [ADDR_W-1:0] head_inst_pos_in,
  input  logic [ADDR_W-1:0] head_rollback_pos_in,
  output logic              head_pop_out,
  output logic              reg_we_out,
  output logic [REG_W-1:0]  reg_rd_out,
  output logic [DATA_W-1:0] reg_data_out,
  output logic [ROB_W-1:0]  reg_rob_id_out,
  output logic              store_req_out,
  output logic [ROB_W-1:0]  store_rob_id_out,
  input  logic              store_ack_in,
  output logic              enable_to_predictor,
  output logic              jump_result_to_predictor,
  output logic [ADDR_W-1:0] inst_pos_to_predictor,
  output logic              flush_out,
  output logic [ADDR_W-1:0] redirect_pc_out,
  output logic [31:0]       commit_count_out
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  commit_state_e     state, state_d;
  logic [FC_W-1:0]   cnt, cnt_d;
  logic              reg_we_d;
  logic [REG_W-1:0]  reg_rd_d;
  logic [DATA_W-1:0] reg_data_d;
  logic [ROB_W-1:0]  reg_rob_id_d;
  logic              store_req_d;
  logic [ROB_W-1:0]  store_rob_id_d;
  logic              pred_en_d;
  logic              pred_res_d;
  logic [ADDR_W-1:0] pred_pos_d;
  logic              flush_d;
  logic [ADDR_W-1:0] redirect_d;
  logic [31:0]       count_d;
  logic              is_store;
  logic              is_jump;

  assign is_store = (head_kind_in == KIND_STORE);
  assign is_jump  = (head_kind_in == KIND_JUMP);

  // Next-state and next-output decode; pulses default low.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    head_pop_out   = 1'b0;
    reg_we_d       = 1'b0;
    reg_rd_d       = reg_rd_out;
    reg_data_d     = reg_data_out;
    reg_rob_id_d   = reg_rob_id_out;
    store_req_d    = store_req_out;
    store_rob_id_d = store_rob_id_out;
    pred_en_d      = 1'b0;
    pred_res_d     = jump_result_to_predictor;
    pred_pos_d     = inst_pos_to_predictor;
    flush_d        = flush_out;
    redirect_d     = redirect_pc_out;
    count_d        = commit_count_out;
    if (rdy_in) begin
      unique case (state)
        ST_COMMIT: begin
          if (head_valid_in && head_ready_in) begin
            if (is_store) begin
              store_req_d    = 1'b1;
              store_rob_id_d = head_rob_id_in;
              state_d        = ST_STORE_WAIT;
            end else begin
              head_pop_out = 1'b1;
              count_d      = commit_count_out + 32'd1;
              if (head_rd_in != '0) begin
                reg_we_d     = 1'b1;
                reg_rd_d     = head_rd_in;
                reg_data_d   = head_value_in;
                reg_rob_id_d = head_rob_id_in;
              end
              if (is_jump) begin
                pred_en_d  = 1'b1;
                pred_res_d = head_real_jumped_in;
                pred_pos_d = head_inst_pos_in;
                if (head_pred_jumped_in != head_real_jumped_in) begin
                  flush_d    = 1'b1;
                  redirect_d = head_rollback_pos_in;
                  cnt_d      = FC_W'(FLUSH_CYCLES - 1);
                  state_d    = ST_FLUSH;
                end
              end
            end
          end
        end
        ST_STORE_WAIT: begin
          if (store_ack_in) begin
            head_pop_out = 1'b1;
            count_d      = commit_count_out + 32'd1;
            store_req_d  = 1'b0;
            state_d      = ST_COMMIT;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            flush_d    = 1'b0;
            redirect_d = '0;
            state_d    = ST_COMMIT;
          end else begin
            cnt_d = cnt - FC_W'(1);
          end
        end
        default: state_d = ST_COMMIT;
      endcase
    end
  end

  // State, flush down-counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                    <= ST_COMMIT;
      cnt                      <= '0;
      reg_we_out               <= 1'b0;
      reg_rd_out               <= '0;
      reg_data_out             <= '0;
      reg_rob_id_out           <= '0;
      store_req_out            <= 1'b0;
      store_rob_id_out         <= '0;
      enable_to_predictor      <= 1'b0;
      jump_result_to_predictor <= 1'b0;
      inst_pos_to_predictor    <= '0;
      flush_out                <= 1'b0;
      redirect_pc_out          <= '0;
      commit_count_out         <= '0;
    end else begin
      state                    <= state_d;
      cnt                      <= cnt_d;
      reg_we_out               <= reg_we_d;
      reg_rd_out               <= reg_rd_d;
      reg_data_out             <= reg_data_d;
      reg_rob_id_out           <= reg_rob_id_d;
      store_req_out            <= store_req_d;
      store_rob_id_out         <= store_rob_id_d;
      enable_to_predictor      <= pred_en_d;
      jump_result_to_predictor <= pred_res_d;
      inst_pos_to_predictor    <= pred_pos_d;
      flush_out                <= flush_d;
      redirect_pc_out          <= redirect_d;
      commit_count_out         <= count_d;
    end
  end

endmodule
